// File: rtl/demux_seq_ctrl.sv
// Sequencer for a 1:8 demux: drives select `s` and data `a` with a start/busy/done
// handshake, sweeping all channels or pulsing one, with break-before-make gaps.
module demux_seq_ctrl #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [SEL_W-1:0]   ch_in,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               a_in,
  input  logic               abort,
  output logic [SEL_W-1:0]   s,
  output logic               a,
  output logic               active,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  // state | meaning
  // IDLE  | waiting for start; a low, s holds last channel
  // DRIVE | a driven with latched data for dwell cycles
  // GAP   | one cycle a low before s advances
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [SEL_W-1:0] LAST_CH = '1;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   s_q, s_d;
  logic               a_q, a_d;
  logic               active_q, active_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;
  logic               ain_q, ain_d;
  logic [DWELL_W-1:0] dwell_eff;

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      a_q       <= 1'b0;
      active_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cnt_q     <= '0;
      dwell_q   <= '0;
      mode_q    <= 1'b0;
      ain_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      a_q       <= a_d;
      active_q  <= active_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      cnt_q     <= cnt_d;
      dwell_q   <= dwell_d;
      mode_q    <= mode_d;
      ain_q     <= ain_d;
    end
  end

  // Outputs are computed for the state being entered, so every output is a flop.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    a_d       = 1'b0;
    active_d  = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    cnt_d     = cnt_q;
    dwell_d   = dwell_q;
    mode_d    = mode_q;
    ain_d     = ain_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = DRIVE;
          mode_d    = mode;
          ain_d     = a_in;
          dwell_d   = dwell_eff;
          s_d       = mode ? ch_in : '0;
          a_d       = a_in;
          active_d  = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = dwell_eff - 1'b1;
          aborted_d = 1'b0;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          if (mode_q || (s_q == LAST_CH)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
            busy_d  = 1'b1;
          end
        end else begin
          cnt_d    = cnt_q - 1'b1;
          a_d      = ain_q;
          active_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else begin
          state_d  = DRIVE;
          s_d      = s_q + 1'b1;
          cnt_d    = dwell_q - 1'b1;
          a_d      = ain_q;
          active_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s       = s_q;
  assign a       = a_q;
  assign active  = active_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_demux_seq_ctrl.sv
// Directed self-checking bench for demux_seq_ctrl; outputs sampled on the falling edge.
module tb_demux_seq_ctrl;

  logic       clk, rst, start, mode, a_in, abort;
  logic [2:0] ch_in;
  logic [7:0] dwell;
  logic [2:0] s;
  logic       a, active, busy, done, aborted;

  int checks = 0;
  int errors = 0;
  logic       mon_en = 1'b0;
  logic [2:0] prev_s = '0;
  logic       prev_a = 1'b0;

  demux_seq_ctrl #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .ch_in(ch_in),
    .dwell(dwell), .a_in(a_in), .abort(abort), .s(s), .a(a),
    .active(active), .busy(busy), .done(done), .aborted(aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // s may only move when a was low in the preceding cycle.
  always @(negedge clk) begin
    if (mon_en && !rst && (s !== prev_s)) begin
      checks++;
      if (prev_a !== 1'b0) begin
        errors++;
        $display("FAIL bbm: s changed %0d->%0d while a was %b", prev_s, s, prev_a);
      end
    end
    prev_s = s;
    prev_a = a;
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({s, a, busy, done, aborted, active} !== 8'b0) begin
      errors++;
      $display("FAIL reset: s=%0d a=%b busy=%b done=%b aborted=%b active=%b want all 0",
               s, a, busy, done, aborted, active);
    end
  endtask

  task automatic test_sweep;
    logic [2:0] es;
    logic       ea, eb, ed;
    mode = 1'b0; dwell = 8'd3; a_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= 32; i++) begin
      eb = (i < 31);
      ed = (i == 31);
      es = (i < 31) ? 3'(i / 4) : 3'd7;
      ea = (i < 31) && ((i % 4) < 3);
      checks++;
      if ({s, a, active, busy, done, aborted} !== {es, ea, ea, eb, ed, 1'b0}) begin
        errors++;
        $display("FAIL sweep cyc%0d: s=%0d a=%b act=%b busy=%b done=%b abt=%b want s=%0d a=%b act=%b busy=%b done=%b abt=0",
                 i, s, a, active, busy, done, aborted, es, ea, ea, eb, ed);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single;
    mode = 1'b1; ch_in = 3'd5; dwell = 8'd0; a_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({s, a, active, busy, done} !== {3'd5, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single drive: s=%0d a=%b act=%b busy=%b done=%b want 5 1 1 1 0", s, a, active, busy, done);
    end
    @(negedge clk);
    checks++;
    if ({s, a, busy, done, aborted} !== {3'd5, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single done: s=%0d a=%b busy=%b done=%b abt=%b want 5 0 0 1 0", s, a, busy, done, aborted);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL single done width: done=%b want 0", done);
    end
  endtask

  task automatic test_start_ignored;
    logic [2:0] es;
    logic       ea, eb, ed;
    int         n_done = 0;
    mode = 1'b0; dwell = 8'd2; a_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= 25; i++) begin
      eb = (i < 23);
      ed = (i == 23);
      es = (i < 23) ? 3'(i / 3) : 3'd7;
      ea = (i < 23) && ((i % 3) < 2);
      if (done === 1'b1) n_done++;
      checks++;
      if ({s, a, busy, done} !== {es, ea, eb, ed}) begin
        errors++;
        $display("FAIL ignore cyc%0d: s=%0d a=%b busy=%b done=%b want s=%0d a=%b busy=%b done=%b",
                 i, s, a, busy, done, es, ea, eb, ed);
      end
      if (i == 5) begin start = 1'b1; mode = 1'b1; ch_in = 3'd2; dwell = 8'd7; a_in = 1'b0; end
      if (i == 7) start = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL ignore done count: got %0d want 1", n_done);
    end
  endtask

  task automatic test_abort_gap;
    int guard;
    mode = 1'b0; dwell = 8'd2; a_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if ({s, a, busy} !== {3'd2, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL abort pre-gap: s=%0d a=%b busy=%b want 2 0 1", s, a, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({s, a, busy, done, aborted} !== {3'd2, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL abort done: s=%0d a=%b busy=%b done=%b abt=%b want 2 0 0 1 1", s, a, busy, done, aborted);
    end
    @(negedge clk);
    checks++;
    if ({done, aborted} !== 2'b01) begin
      errors++;
      $display("FAIL abort hold: done=%b abt=%b want 0 1", done, aborted);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    dwell = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({s, a, busy, aborted} !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL abort restart: s=%0d a=%b busy=%b abt=%b want 0 1 1 0", s, a, busy, aborted);
    end
    guard = 0;
    while (done !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard != 15 || s !== 3'd7 || aborted !== 1'b0) begin
      errors++;
      $display("FAIL restart finish: cycles=%0d s=%0d abt=%b want 15 7 0", guard, s, aborted);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    mode = 1'b0; dwell = 8'd3; a_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    checks++;
    if ({s, a} !== {3'd4, 1'b1}) begin
      errors++;
      $display("FAIL arst pre: s=%0d a=%b want 4 1", s, a);
    end
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({s, a, busy, active} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL arst async: s=%0d a=%b busy=%b act=%b want 0 0 0 0", s, a, busy, active);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    mode = 1'b1; ch_in = 3'd3; dwell = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = 1'b0; ch_in = 3'd6; dwell = 8'd9;
    checks++;
    if ({s, a, busy} !== {3'd3, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL arst rerun c0: s=%0d a=%b busy=%b want 3 1 1", s, a, busy);
    end
    @(negedge clk);
    checks++;
    if ({s, a, busy, done} !== {3'd3, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL arst rerun c1: s=%0d a=%b busy=%b done=%b want 3 1 1 0", s, a, busy, done);
    end
    @(negedge clk);
    checks++;
    if ({s, a, busy, done} !== {3'd3, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL arst rerun done: s=%0d a=%b busy=%b done=%b want 3 0 0 1", s, a, busy, done);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; ch_in = '0; dwell = '0; a_in = 1'b0; abort = 1'b0;
    test_reset;
    mon_en = 1'b1;
    test_sweep;
    test_single;
    test_start_ignored;
    test_abort_gap;
    test_async_reset;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_seq_ctrl.md
Name: demux_seq_ctrl

Overview:
- Upstream sequencer for the 1:8 demux. It drives the demux select `s` and data `a` under a start/busy/done handshake.
- Sweep mode: routes a pulse of programmable dwell to each channel 0..7 in turn. Single mode: routes one pulse to one chosen channel.
- A one-cycle break-before-make gap between channels guarantees the demux never switches channels while `a` is high.

Parameters:
- SEL_W, 3, select width; channel count is 2**SEL_W (8).
- DWELL_W, 8, width of the dwell-length input.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a run; sampled only in IDLE.
- mode  input  1  0 = sweep all channels, 1 = single channel.
- ch_in  input  SEL_W  target channel in single mode.
- dwell  input  DWELL_W  cycles `a` stays high per channel; 0 is treated as 1.
- a_in  input  1  data level driven onto `a` during DRIVE (0 gives a dry run).
- abort  input  1  synchronous abort of the current run.
- s  output  SEL_W  demux select (registered).
- a  output  1  demux data (registered).
- active  output  1  high while in DRIVE.
- busy  output  1  high in DRIVE and GAP.
- done  output  1  one-cycle pulse on run completion.
- aborted  output  1  set with `done` if the run was aborted; held until the next accepted start.

Behaviour:
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset (async, any state): state=IDLE, s=0, a=0, active=0, busy=0, done=0, aborted=0, dwell counter=0.
- State IDLE:
  - Outputs: a=0, busy=0; `s` holds its last value.
  - On an edge with start=1: latch mode, ch_in, a_in and dwell (0 becomes 1); clear aborted; go to DRIVE.
  - Entering DRIVE: s = 0 (sweep) or ch_in (single); a = latched a_in; counter = dwell-1.
- State DRIVE:
  - Outputs: active=1, busy=1, a = latched a_in.
  - Counter decrements each cycle. `a` is high for exactly dwell cycles.
  - Counter==0 and (single mode or s==7): go to DONE.
  - Counter==0 otherwise: go to GAP.
- State GAP (exactly one cycle):
  - Outputs: a=0, active=0, busy=1; `s` unchanged.
  - Next edge: s = s+1, counter reloaded to dwell-1, a restored, go to DRIVE.
  - `s` never changes in a cycle where `a` is high.
- State DONE (one cycle):
  - Outputs: done=1, busy=0, a=0.
  - Next edge: go to IDLE.
- Abort:
  - abort=1 sampled in DRIVE or GAP sends the block to DONE on that edge, with a=0 and aborted=1.
  - abort takes priority over counter expiry in the same cycle.
  - abort is ignored in IDLE and DONE.
- Start outside IDLE is ignored and is not queued. A start held high through DONE is accepted in the following IDLE cycle.
- Inputs mode, ch_in, dwell and a_in may change mid-run with no effect; only the values latched at start are used.
- Latency:
  - Start accepted on edge k: first DRIVE outputs are visible after edge k.
  - Sweep with dwell D: busy for 8·D + 7 cycles, then done.
  - Single mode: busy for D cycles, then done.
- Sweep ends at s=7; `s` does not wrap past 7.
- Reset asserted mid-run forces a=0 immediately, without waiting for a clock edge.

Test Plan:
- Reset: assert rst for 3 cycles, release -> s=0, a=0, busy=0, done=0, aborted=0.
- Sweep, dwell=3, a_in=1: s steps 0..7.
  - a=1 for 3 cycles per channel, with a 1-cycle a=0 gap between channels.
  - busy for 31 cycles, then done=1 for exactly 1 cycle.
  - A monitor confirms `s` never changes while a=1.
- Single mode, ch_in=5, dwell=0: s=5, a=1 for exactly 1 cycle, then done; aborted=0.
- Start ignored while busy: pulse start again mid-sweep with ch_in=2 and mode=1 -> sweep continues unchanged to s=7, with one done pulse.
- Abort in GAP after channel 2:
  - Next cycle: a=0, done=1, aborted=1, s=2.
  - A new start clears aborted and restarts the sweep at s=0.
- Async reset mid-DRIVE on channel 4 -> a=0, s=0, busy=0 before the next clk edge; a start after release runs normally.
